// File: rtl/multicore_mem_arbiter.sv
// Shared single-port data RAM arbiter for the multicore build, plus end-of-program aggregation.
// Define MCARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module multicore_mem_arbiter #(
    parameter int NCORES = 3,
    parameter int DATA_W = 24,
    parameter int ADDR_W = 16
) (
    input  logic                     clk2,
    input  logic                     controlRST,
    input  logic                     clock_en,
    input  logic [NCORES-1:0]        core_req,
    input  logic [NCORES-1:0]        core_we,
    input  logic [NCORES*ADDR_W-1:0] core_addr,
    input  logic [NCORES*DATA_W-1:0] core_wdata,
    input  logic [NCORES-1:0]        core_end,
    output logic [NCORES-1:0]        core_gnt,
    output logic [NCORES-1:0]        core_rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     endp
);

    localparam int IDX_W = $clog2(NCORES);
    localparam int SUM_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RWAIT  = 2'd2,
        RDONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [NCORES-1:0]   core_gnt_q;
    logic [NCORES-1:0]   core_rvalid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                endp_q;
    logic [NCORES-1:0]   done_q;
    logic [IDX_W-1:0]    wsel_q;

    logic [NCORES-1:0]   eligible;
    logic                win_found_d;
    logic [IDX_W-1:0]    win_idx_d;

    logic [ADDR_W-1:0]   addr_arr  [NCORES];
    logic [DATA_W-1:0]   wdata_arr [NCORES];

    for (genvar gi = 0; gi < NCORES; gi++) begin : g_unpack
        assign addr_arr[gi]  = core_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = core_wdata[gi*DATA_W +: DATA_W];
    end

    // A core that has signalled end-of-program is masked out of arbitration for good.
    assign eligible = core_req & ~done_q;

`ifdef MCARB_FIXED_PRIO_EN
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = '0;
        for (int k = NCORES - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                win_found_d = 1'b1;
                win_idx_d   = IDX_W'(k);
            end
        end
    end
`else
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] cand [NCORES];

    // cand[k] is the core searched (k+1) positions after the previous winner.
    for (genvar gi = 0; gi < NCORES; gi++) begin : g_rr
        logic [SUM_W-1:0] sum;
        assign sum      = {1'b0, last_q} + SUM_W'(gi + 1);
        assign cand[gi] = (sum >= SUM_W'(NCORES)) ? IDX_W'(sum - SUM_W'(NCORES))
                                                  : sum[IDX_W-1:0];
    end

    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = '0;
        for (int k = NCORES - 1; k >= 0; k--) begin
            if (eligible[cand[k]]) begin
                win_found_d = 1'b1;
                win_idx_d   = cand[k];
            end
        end
    end

    always_ff @(posedge clk2) begin
        if (!controlRST) begin
            last_q <= IDX_W'(NCORES - 1);
        end else if (state_q == IDLE && clock_en && win_found_d) begin
            last_q <= win_idx_d;
        end
    end
`endif

    always_ff @(posedge clk2) begin
        if (!controlRST) begin
            state_q       <= IDLE;
            core_gnt_q    <= '0;
            core_rvalid_q <= '0;
            rdata_q       <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            endp_q        <= 1'b0;
            done_q        <= '0;
            wsel_q        <= '0;
        end else begin
            core_gnt_q    <= '0;
            core_rvalid_q <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            done_q        <= done_q | core_end;
            endp_q        <= &done_q;
            case (state_q)
                IDLE: begin
                    if (clock_en && win_found_d) begin
                        state_q     <= ACCESS;
                        core_gnt_q  <= NCORES'(1) << win_idx_d;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= core_we[win_idx_d];
                        mem_addr_q  <= addr_arr[win_idx_d];
                        mem_wdata_q <= wdata_arr[win_idx_d];
                        wsel_q      <= win_idx_d;
                    end
                end
                ACCESS: state_q <= mem_we_q ? IDLE : RWAIT;
                RWAIT: begin
                    state_q       <= RDONE;
                    rdata_q       <= mem_rdata;
                    core_rvalid_q <= NCORES'(1) << wsel_q;
                end
                RDONE:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign core_gnt    = core_gnt_q;
    assign core_rvalid = core_rvalid_q;
    assign rdata       = rdata_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign endp        = endp_q;

endmodule

// File: doc/multicore_mem_arbiter.md
# multicore_mem_arbiter

Arbitrates a single-port shared data RAM between the processor cores of the multicore build. Each core raises a request carrying an address, a write enable and 24-bit write data. The arbiter serialises the requests, drives the RAM and returns read data with a one-hot valid. It also aggregates per-core end-of-program indications into the single `endp` flag seen at the multicore top.

## Interface
- `NCORES`, 3, number of requesting cores (2..8)
- `DATA_W`, 24, data width (matches the core bus width)
- `ADDR_W`, 16, RAM word-address width
- `clk2`  in  1  system clock; all logic on the rising edge
- `controlRST`  in  1  reset, synchronous, active-low
- `clock_en`  in  1  arbitration enable; 0 blocks new grants
- `core_req`  in  NCORES  access request per core, level
- `core_we`  in  NCORES  1 = write, 0 = read
- `core_addr`  in  NCORES*ADDR_W  packed addresses; core i at bits [i*ADDR_W +: ADDR_W]
- `core_wdata`  in  NCORES*DATA_W  packed write data, same packing
- `core_end`  in  NCORES  end-of-program pulse or level per core
- `core_gnt`  out  NCORES  one-hot, one-cycle request-accepted pulse
- `core_rvalid`  out  NCORES  one-hot, one-cycle read-data-valid pulse
- `rdata`  out  DATA_W  registered read data, broadcast to all cores
- `mem_en`, `mem_we`  out  1  RAM strobe and write enable
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wdata`  out  DATA_W  RAM write data
- `mem_rdata`  in  DATA_W  RAM read data, valid the cycle after `mem_en` for a read
- `endp`  out  1  all cores ended, sticky

## Operation
- FSM states:
  - IDLE
  - ACCESS: `mem_en` = 1 for exactly this cycle
  - RWAIT: RAM produces `mem_rdata`
  - RDONE: `core_rvalid` pulse
- Transitions:
  - IDLE→ACCESS on an edge where `clock_en` = 1 and at least one eligible request is present.
  - ACCESS→IDLE for a write.
  - ACCESS→RWAIT for a read.
  - RWAIT→RDONE always.
  - RDONE→IDLE always.
- On the IDLE→ACCESS edge, the arbiter registers the following into `mem_*` and asserts `core_gnt[w]`:
  - winner index w
  - `core_we[w]`
  - `core_addr[w]`
  - `core_wdata[w]`
- The core may change its address and data after seeing grant. It must drop `core_req` on the edge where it samples `core_gnt`; a request still high in the next IDLE cycle is a new request.
- On the RWAIT→RDONE edge, `rdata` ← `mem_rdata`. `core_rvalid[w]` = 1 during RDONE. `rdata` holds its value until the next read.
- Round-robin:
  - Pointer `last` = index of the previous winner.
  - Search order is `last`+1, `last`+2, … modulo NCORES.
  - `last` updates on every grant.
- Eligible request: `core_req[i]` = 1 and `done[i]` = 0.
- `done[i]` is set on any cycle with `core_end[i]` = 1 and cleared only by reset.
  - A core that has ended is never granted, even if its request stays high.
  - `endp` = AND of all `done[i]`, registered.
- `clock_en` = 0 blocks only the IDLE→ACCESS decision. An in-flight transaction completes normally. `done` tracking continues.

## Timing
- Reset (`controlRST` = 0 at an edge), values after that edge:
  - state = IDLE
  - `last` = NCORES-1, so core 0 has first priority
  - `done` = 0
  - `core_gnt`, `core_rvalid`, `mem_en`, `mem_we`, `endp` = 0
  - `mem_addr`, `mem_wdata`, `rdata` = 0
- Reset mid-transaction aborts it immediately. No `rvalid` follows.
- With request sampled at edge t:
  - grant and `mem_en` are high in cycle t+1
  - for a read, `rvalid` is high in cycle t+3
- Occupancy: write = 2 cycles per access, read = 4 cycles per access (the IDLE cycle included).
- `core_end[i]` at edge t sets `done[i]` at t+1 and `endp` at t+2. A request from that core on edge t+1 or later is ignored. A request granted at edge t completes normally.

## Configuration
- `MCARB_FIXED_PRIO_EN` defined:
  - fixed priority; lowest eligible index wins
  - `last` is not implemented
- Undefined (default): round-robin as specified above.
- Latency, FSM and `endp` behaviour are identical in both builds.

## Test plan
- Reset, then core 0 writes 0xABCDEF to address 0x0010. Required: `core_gnt` = 001 and `mem_en` = `mem_we` = 1 with addr 0x0010 one cycle later. A following read by core 1 of address 0x0010 gives `core_rvalid` = 010 and `rdata` = 0xABCDEF three cycles after its request.
- All three cores hold read requests continuously (each re-raises after its grant). Required grant order 0, 1, 2, 0, 1, 2 (round-robin build). Same stimulus with the macro defined gives core 0 on every arbitration.
- `clock_en` = 0 with requests pending gives no `core_gnt` for 10 cycles. Dropping `clock_en` during ACCESS of a read still produces `core_rvalid` two cycles later.
- Pulse `core_end[1]` while core 1 holds `core_req`. Core 1 is never granted afterwards and cores 0 and 2 alternate. `endp` = 1 exactly 2 cycles after the last of the three `core_end` pulses and stays 1.
- Assert `controlRST` = 0 during RWAIT. Required: no `core_rvalid`, all outputs 0, and core 0 wins the first arbitration after release.
